fetch_redirect_unit: RTL and testbench

Instruction-fetch front end that consumes the taken-branch/jump decision and target produced in execute, and steers the program counter accordingly. It issues in-order instruction reads on a valid/ready memory request channel and collects in-order responses. Fetched words go into a small queue that feeds decode. On a redirect, it discards everything fetched down the wrong path.

---
 rtl/riscv_core_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/fetch_redirect_unit.sv | 116 +++++++++++
 tb/tb_fetch_redirect_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core definitions: datapath widths, reset vector, opcode fields and
// the fetch queue entry layout.
package riscv_core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // opcode[6:2] values shared with the branch decision logic in execute
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary; misalignment traps live in execute.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {pc, instr} between fetch and decode.
// Flush empties it in one cycle; the head outputs hold their last value when empty.
module fetch_queue
    import riscv_core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  last_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_eff;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop_eff) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            // Remember what decode last saw so the outputs stay put once empty.
            if (count_q != '0) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: in-order instruction requests with credit-based flow control,
// redirect on taken branch/jump, and squashing of wrong-path responses.
module fetch_redirect_unit
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              QUEUE_DEPTH     = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    output logic            imem_req_valid_out,
    input  logic            imem_req_ready_in,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_rsp_valid_in,
    input  logic [ILEN-1:0] imem_rsp_data_in,
    output logic            instr_valid_out,
    input  logic            instr_ready_in,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc_out
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW = $clog2(QUEUE_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OCW-1:0]  outstanding_q, outstanding_d;
    logic [OCW-1:0]  drop_cnt_q, drop_cnt_d;

    logic            req_valid, req_fire;
    logic            rsp_live, rsp_drop;
    logic            q_push, q_pop, q_valid;
    logic [QCW-1:0]  q_count;
    fetch_entry_t    q_wdata, q_head;

    always_comb begin
        req_valid = 1'b0;
        // Only issue if every live (non-dropped) response already has a queue slot.
        if (!rst_in
            && (int'(outstanding_q) < MAX_OUTSTANDING)
            && ((int'(outstanding_q) - int'(drop_cnt_q) + int'(q_count)) < QUEUE_DEPTH)) begin
            req_valid = 1'b1;
        end
    end

    assign req_fire = req_valid && imem_req_ready_in;
    assign rsp_live = imem_rsp_valid_in && (outstanding_q != '0);
    assign rsp_drop = rsp_live && (drop_cnt_q != '0);
    assign q_push   = rsp_live && !rsp_drop && !branch_taken_in;
    assign q_pop    = q_valid && instr_ready_in;
    assign q_wdata  = '{pc: rsp_pc_q, instr: imem_rsp_data_in};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + OCW'(req_fire) - OCW'(rsp_live);
        drop_cnt_d    = drop_cnt_q - OCW'(rsp_drop);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (q_push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (branch_taken_in) begin
            // Everything still in flight after this cycle belongs to the wrong path.
            fetch_pc_d = align_word(branch_target_in);
            rsp_pc_d   = align_word(branch_target_in);
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .flush_i     (branch_taken_in),
        .push_i      (q_push),
        .push_data_i (q_wdata),
        .pop_i       (q_pop),
        .valid_o     (q_valid),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    assign imem_req_valid_out = req_valid;
    assign imem_addr_out      = fetch_pc_q;
    assign instr_valid_out    = q_valid;
    assign instr_out          = q_head.instr;
    assign instr_pc_out       = q_head.pc;

    // A response with nothing outstanding is a memory protocol violation; it is ignored.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            assert (!(imem_rsp_valid_in && (outstanding_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit: a driver with an in-order memory model,
// and a scoreboard monitor comparing decode output against program-order expectations.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [31:0] br_tgt = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        ivalid;
    logic        iready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          epoch;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          epoch = 0;
    logic [31:0] model_pc = RESET_PC;
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic        rst_prev = 1'b0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_instr = '0;

    fetch_redirect_unit #(
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MAX_OUT),
        .QUEUE_DEPTH     (2)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .branch_taken_in    (br),
        .branch_target_in   (br_tgt),
        .imem_req_valid_out (req_valid),
        .imem_req_ready_in  (req_ready),
        .imem_addr_out      (req_addr),
        .imem_rsp_valid_in  (rsp_valid),
        .imem_rsp_data_in   (rsp_data),
        .instr_valid_out    (ivalid),
        .instr_ready_in     (iready),
        .instr_out          (instr),
        .instr_pc_out       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic do_cycle(input int p_ready, input int p_iready, input int p_br,
                            input int p_rsp, input bit do_rst, input bit force_br,
                            input logic [31:0] force_tgt);
        logic [31:0] a;
        @(negedge clk);
        rst       = do_rst;
        req_ready = ($urandom_range(0, 99) < p_ready);
        iready    = ($urandom_range(0, 99) < p_iready);
        br        = !do_rst && (force_br || ($urandom_range(0, 99) < p_br));
        br_tgt    = force_br ? force_tgt : {22'd0, 10'($urandom_range(0, 1023))};
        if (!do_rst && mem_q.size() > 0 && $urandom_range(0, 99) < p_rsp) begin
            a         = mem_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = mem_word(a);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;
        if (do_rst) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            checks++;
            if (req_addr !== model_pc)
                $display("FAIL fetch_addr: got %08h want %08h", req_addr, model_pc);
            if (req_addr !== model_pc) errors++;
            if (req_valid && req_ready) begin
                checks++;
                if (mem_q.size() + int'(rsp_valid) >= MAX_OUT) begin
                    errors++;
                    $display("FAIL max_outstanding: got %0d in flight before accept, limit %0d",
                             mem_q.size() + int'(rsp_valid), MAX_OUT);
                end
                mem_q.push_back(req_addr);
                exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc), epoch: epoch});
                model_pc += 32'd4;
            end
            if (br) model_pc = {br_tgt[31:2], 2'b00};
        end
    endtask

    // Scoreboard monitor: samples two time units after the driver settles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (rst_prev) begin
                    checks++;
                    if (req_valid !== 1'b0 || ivalid !== 1'b0 || req_addr !== RESET_PC
                        || instr !== 32'h0 || instr_pc !== 32'h0) begin
                        errors++;
                        $display("FAIL reset_outputs: got rv=%b iv=%b addr=%08h instr=%08h pc=%08h want 0 0 %08h 0 0",
                                 req_valid, ivalid, req_addr, instr, instr_pc, RESET_PC);
                    end
                end
                last_pc    = '0;
                last_instr = '0;
            end else begin
                if (ivalid) begin
                    last_pc    = instr_pc;
                    last_instr = instr;
                end else begin
                    checks++;
                    if (instr !== last_instr || instr_pc !== last_pc) begin
                        errors++;
                        $display("FAIL empty_hold: got pc=%08h instr=%08h want pc=%08h instr=%08h",
                                 instr_pc, instr, last_pc, last_instr);
                    end
                end
                if (ivalid && iready) begin
                    while (exp_q.size() > 0 && exp_q[0].epoch != epoch) void'(exp_q.pop_front());
                    checks++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL decode_unexpected: got pc=%08h instr=%08h want nothing", instr_pc, instr);
                    end else begin
                        if (instr_pc !== exp_q[0].pc || instr !== exp_q[0].instr) begin
                            errors++;
                            $display("FAIL decode_word: got pc=%08h instr=%08h want pc=%08h instr=%08h",
                                     instr_pc, instr, exp_q[0].pc, exp_q[0].instr);
                        end
                        void'(exp_q.pop_front());
                    end
                end
                if (br) epoch++;
            end
            rst_prev = rst;
        end
    end

    initial begin
        int live;
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 1'b1, 1'b0, 32'h0);
        // Sequential fetch from RESET_PC with a one-cycle memory
        for (int i = 0; i < 20; i++) do_cycle(100, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        // Credit stall: decode stops consuming
        for (int i = 0; i < 12; i++) do_cycle(100, 0, 0, 100, 1'b0, 1'b0, 32'h0);
        checks++;
        if (req_valid !== 1'b0 || ivalid !== 1'b1) begin
            errors++;
            $display("FAIL credit_stall: got req_valid=%b instr_valid=%b want 0 1", req_valid, ivalid);
        end
        // Resume, then a redirect with requests in flight
        for (int i = 0; i < 4; i++) do_cycle(100, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        do_cycle(100, 100, 0, 0, 1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) do_cycle(100, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        // Misaligned target followed by a three-cycle memory stall
        do_cycle(100, 100, 0, 100, 1'b0, 1'b1, 32'h0000_0203);
        for (int i = 0; i < 3; i++) do_cycle(0, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) do_cycle(100, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        // Random traffic with occasional redirects
        for (int i = 0; i < 300; i++) do_cycle(70, 70, 8, 70, 1'b0, 1'b0, 32'h0);
        // Fill the queue, then reset mid-operation
        for (int i = 0; i < 8; i++) do_cycle(100, 0, 0, 50, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) do_cycle(100, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        // Dense redirects colliding with accepts and responses
        for (int i = 0; i < 300; i++) do_cycle(80, 80, 25, 80, 1'b0, 1'b0, 32'h0);
        // Drain: stop issuing, let everything land and be consumed
        for (int i = 0; i < 10; i++) do_cycle(0, 100, 0, 100, 1'b0, 1'b0, 32'h0);
        #3;
        live = 0;
        foreach (exp_q[k]) if (exp_q[k].epoch == epoch) live++;
        checks++;
        if (live != 0 || ivalid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got %0d undelivered words, instr_valid=%b want 0 0", live, ivalid);
        end
        checks++;
        if (pops < 100) begin
            errors++;
            $display("FAIL progress: got %0d instructions delivered want at least 100", pops);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
